// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - FIFO read-port to valid/ready stream adapter with 2-entry skid buffer
//
// Purpose:
//   Drains a synchronous FIFO with a one-cycle registered read latency and
//   presents the words on a valid/ready stream. A 2-entry skid buffer lets the
//   reader keep one read in flight while still honouring backpressure, so a
//   word per clock is sustained while the FIFO is non-empty and downstream is
//   ready. A free-running counter tracks completed stream handshakes.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   fifo_empty  in   FIFO empty flag
//   fifo_dout   in   FIFO read data, valid the cycle after an accepted read
//   fifo_rd_en  out  FIFO pop request
//   m_valid     out  stream data valid
//   m_ready     in   stream downstream ready
//   m_data      out  stream data (head of the skid buffer)
//   xfer_count  out  completed handshakes, modulo 2^cnt_w
//   busy        out  buffer holds data or a FIFO read is in flight

module fifo_stream_reader #(
  parameter int width = 8,
  parameter int cnt_w = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [width-1:0] fifo_dout,
  output logic             fifo_rd_en,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [width-1:0] m_data,
  output logic [cnt_w-1:0] xfer_count,
  output logic             busy
);

  // Skid buffer state: r_entry0 is the head; r_occ counts valid entries 0..2.
  logic [1:0]       r_occ;
  logic             r_inflight;
  logic [width-1:0] r_entry0;
  logic [width-1:0] r_entry1;
  logic [cnt_w-1:0] r_count;

  logic             w_pop;
  logic             w_cap;
  logic [2:0]       w_level;
  logic             w_rd_en;
  logic [1:0]       w_nxt_occ;
  logic [width-1:0] w_nxt_e0;
  logic [width-1:0] w_nxt_e1;

  assign w_pop = m_valid & m_ready;
  assign w_cap = r_inflight;

  // Projected buffer fill after this cycle's pop, counting the word already
  // in flight. A pop implies r_occ >= 1, so this never underflows.
  assign w_level = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};

  // Issuing a read only when the projected fill is below 2 guarantees there
  // is always a slot for the word that lands next cycle.
  assign w_rd_en = !rst && !fifo_empty && (w_level < 3'd2);

  // Buffer update. A captured word lands at index (r_occ - pop); on a pop the
  // second entry shifts to the head. When the buffer drains to empty the head
  // is left untouched so m_data holds its last value.
  always_comb begin
    w_nxt_occ = r_occ;
    w_nxt_e0  = r_entry0;
    w_nxt_e1  = r_entry1;
    case ({w_pop, w_cap})
      2'b11: begin
        if (r_occ == 2'd2) begin
          w_nxt_e0 = r_entry1;
          w_nxt_e1 = fifo_dout;
        end else begin
          w_nxt_e0 = fifo_dout;
        end
      end
      2'b10: begin
        if (r_occ == 2'd2) begin
          w_nxt_e0 = r_entry1;
        end
        w_nxt_occ = r_occ - 2'd1;
      end
      2'b01: begin
        if (r_occ == 2'd0) begin
          w_nxt_e0 = fifo_dout;
        end else begin
          w_nxt_e1 = fifo_dout;
        end
        w_nxt_occ = r_occ + 2'd1;
      end
      default: begin
      end
    endcase
  end

  // Reset takes priority over capture, so a read that was in flight when
  // reset hit is dropped and its data never enters the buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
      r_entry0   <= '0;
      r_entry1   <= '0;
      r_count    <= '0;
    end else begin
      r_occ      <= w_nxt_occ;
      r_inflight <= w_rd_en;
      r_entry0   <= w_nxt_e0;
      r_entry1   <= w_nxt_e1;
      if (w_pop) begin
        r_count <= r_count + cnt_w'(1);
      end
    end
  end

  assign fifo_rd_en = w_rd_en;
  assign m_valid    = (r_occ != 2'd0);
  assign m_data     = r_entry0;
  assign xfer_count = r_count;
  assign busy       = (r_occ != 2'd0) | r_inflight;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - self-checking bench for fifo_stream_reader

module tb_fifo_stream_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m_ready = 1'b0;
  logic [7:0]  fifo_dout = 8'h00;
  logic        fifo_empty;
  logic        fifo_rd_en, m_valid, busy;
  logic [7:0]  m_data;
  logic [15:0] xfer_count;
  logic        fifo_rd_en4, m_valid4, busy4;
  logic [7:0]  m_data4;
  logic [3:0]  xfer_count4;

  // Bench-side FIFO: pushed by the stimulus, popped on fifo_rd_en.
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int wr_cnt = 0;
  int rd_cnt = 0;
  assign fifo_empty = (wr_cnt == rd_cnt);

  int checks = 0;
  int errors = 0;

  // Reference bookkeeping since the last reset.
  int   hs = 0;
  int   reads = 0;
  logic inflight_b = 1'b0;

  int ncyc = 0;
  int rd_pulses = 0;
  int first_rd = -1;
  int first_val = -1;
  int first_hs = -1;
  int last_hs = -1;
  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic [7:0] prev_data = 8'h00;

  fifo_stream_reader #(.width(8), .cnt_w(16)) u_dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .xfer_count(xfer_count), .busy(busy)
  );

  // Narrow-counter instance driven by the same inputs; only its count is used.
  fifo_stream_reader #(.width(8), .cnt_w(4)) u_dut4 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rd_en(fifo_rd_en4), .m_valid(m_valid4), .m_ready(m_ready),
    .m_data(m_data4), .xfer_count(xfer_count4), .busy(busy4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [7:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    wr_cnt++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      step();
      n++;
    end
    repeat (3) step();
    chk("drain_done", 32'(exp_q.size()), 32'd0);
  endtask

  always @(posedge clk) begin
    if (fifo_rd_en && fifo_q.size() != 0) begin
      fifo_dout <= fifo_q.pop_front();
      rd_cnt    <= rd_cnt + 1;
    end
    if (rst) begin
      hs         <= 0;
      reads      <= 0;
      inflight_b <= 1'b0;
    end else begin
      if (fifo_rd_en) reads <= reads + 1;
      if (m_valid && m_ready) hs <= hs + 1;
      inflight_b <= fifo_rd_en;
    end
  end

  always @(negedge clk) begin
    ncyc++;
    if (rst) begin
      chk("rd_en_in_reset", 32'(fifo_rd_en), 32'd0);
      prev_valid = 1'b0;
    end else begin
      if (fifo_rd_en) begin
        rd_pulses++;
        if (first_rd < 0) first_rd = ncyc;
      end
      if (m_valid && first_val < 0) first_val = ncyc;
      if (fifo_empty) chk("rd_en_while_empty", 32'(fifo_rd_en), 32'd0);
      chk("occupancy_le_2", 32'((reads - hs) <= 2), 32'd1);
      chk("busy", 32'(busy), 32'((reads - hs) != 0));
      chk("m_valid", 32'(m_valid), 32'((reads - hs - 32'(inflight_b)) != 0));
      chk("xfer_count", 32'(xfer_count), 32'(hs[15:0]));
      chk("xfer_count4", 32'(xfer_count4), 32'(hs[3:0]));
      if (prev_valid && !prev_ready) begin
        chk("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_data", 32'(m_data), 32'(prev_data));
      end
      if (m_valid && m_ready) begin
        if (first_hs < 0) first_hs = ncyc;
        last_hs = ncyc;
        chk("word_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("m_data_order", 32'(m_data), 32'(exp_q.pop_front()));
      end
      prev_valid = m_valid;
      prev_ready = m_ready;
      prev_data  = m_data;
    end
  end

  initial begin
    int p0;
    int n;
    logic s15, s16;

    // Reset state.
    rst = 1'b1;
    repeat (2) step();
    @(negedge clk);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_xfer_count", 32'(xfer_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    step();
    rst = 1'b0;

    // Reset while a read is in flight: 0x11 is in flight and must be dropped.
    m_ready = 1'b0;
    push(8'h11); push(8'h22); push(8'h33);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    void'(exp_q.pop_front());
    @(negedge clk);
    chk("midrst_m_valid", 32'(m_valid), 32'd0);
    chk("midrst_xfer_count", 32'(xfer_count), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_m_data", 32'(m_data), 32'd0);
    step();
    @(negedge clk);
    chk("midrst_no_capture_valid", 32'(m_valid), 32'd0);
    chk("midrst_no_capture_data", 32'(m_data), 32'd0);
    step();
    m_ready = 1'b1;
    drain(50);
    chk("midrst_final_count", 32'(xfer_count), 32'd2);

    // Streaming 16 words with m_ready held high.
    do_reset();
    first_rd = -1; first_val = -1; first_hs = -1; last_hs = -1;
    for (int i = 1; i <= 16; i++) push(8'(i));
    drain(100);
    chk("stream_latency", 32'(first_val - first_rd), 32'd2);
    chk("stream_consecutive", 32'(last_hs - first_hs), 32'd15);
    chk("stream_count", 32'(xfer_count), 32'd16);

    // Backpressure: 10-cycle stall then release.
    do_reset();
    m_ready = 1'b0;
    p0 = rd_pulses;
    for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
    repeat (10) step();
    @(negedge clk);
    chk("bp_rd_pulses", 32'(rd_pulses - p0), 32'd2);
    chk("bp_m_valid", 32'(m_valid), 32'd1);
    chk("bp_m_data", 32'(m_data), 32'hA0);
    first_hs = -1; last_hs = -1;
    step();
    m_ready = 1'b1;
    drain(50);
    chk("bp_no_gaps", 32'(last_hs - first_hs), 32'd4);
    chk("bp_count", 32'(xfer_count), 32'd5);

    // Empty handling, then a single word.
    do_reset();
    m_ready = 1'b1;
    p0 = rd_pulses;
    repeat (10) step();
    @(negedge clk);
    chk("empty_rd_pulses", 32'(rd_pulses - p0), 32'd0);
    chk("empty_m_valid", 32'(m_valid), 32'd0);
    chk("empty_busy", 32'(busy), 32'd0);
    step();
    push(8'h5A);
    repeat (6) step();
    @(negedge clk);
    chk("single_rd_pulses", 32'(rd_pulses - p0), 32'd1);
    chk("single_count", 32'(xfer_count), 32'd1);
    chk("single_busy", 32'(busy), 32'd0);
    chk("single_delivered", 32'(exp_q.size()), 32'd0);

    // Random ready over 200 words.
    do_reset();
    for (int i = 0; i < 200; i++) push(8'($urandom));
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      step();
      m_ready = 1'($urandom_range(0, 1));
      n++;
    end
    m_ready = 1'b1;
    drain(20);
    chk("random_count", 32'(xfer_count), 32'd200);

    // Counter wrap on the 4-bit instance.
    do_reset();
    m_ready = 1'b1;
    s15 = 1'b0; s16 = 1'b0;
    for (int i = 0; i < 20; i++) push(8'(i + 100));
    n = 0;
    while (hs < 20 && n < 200) begin
      @(negedge clk);
      if (hs == 15 && !s15) begin
        chk("wrap_at_15", 32'(xfer_count4), 32'd15);
        s15 = 1'b1;
      end
      if (hs == 16 && !s16) begin
        chk("wrap_at_16", 32'(xfer_count4), 32'd0);
        s16 = 1'b1;
      end
      n++;
    end
    @(negedge clk);
    chk("wrap_seen_15", 32'(s15), 32'd1);
    chk("wrap_seen_16", 32'(s16), 32'd1);
    chk("wrap_final4", 32'(xfer_count4), 32'd4);
    chk("wrap_final16", 32'(xfer_count), 32'd20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
